uart_tx_fifo_cfg: RTL

Parametrised UART transmitter with a small input FIFO. It supports runtime-selectable parity (none/even/odd) and one or two stop bits. The block sits between the byte producer and the serial pin and is paced by the shared baud-rate generator's oversampling tick. Frames go out LSB-first with back-to-back transmission and no idle gap while data is queued.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/uart_tx_fifo_cfg.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and parity helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest supported data word; narrower words are zero-padded, which leaves the XOR unchanged.
  localparam int PAR_MAX_W = 9;

  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with read/write pointers and an occupancy count.
// Pushes when full and pops when empty are ignored; there is no write-to-read bypass.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a small FIFO, paced by the baud generator's oversample tick.
// Parity mode and stop-bit count are latched per frame when the word is popped.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | line high, waiting for a queued word (stick ignored)
//   ST_START  | start bit low for OVS ticks
//   ST_DATA   | DBIT data bits, LSB first, OVS ticks each
//   ST_PARITY | optional parity bit on the latched word, OVS ticks
//   ST_STOP   | line high for OVS or 2*OVS ticks; pulses tx_done, chains next word
module uart_tx_fifo_cfg #(
  parameter int DBIT  = 8,
  parameter int OVS   = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stick,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic [DBIT-1:0] tx_data,
  input  logic [1:0]      par_mode,
  input  logic            stop2,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);
  import uart_pkg::*;

  localparam int TW = $clog2(2 * OVS);
  localparam int BW = $clog2(DBIT);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [TW-1:0] TICK_LAST1 = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_LAST2 = TW'(2 * OVS - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DBIT - 1);

  uart_state_e     state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] data_q, data_d;
  logic [1:0]      par_q, par_d;
  logic            stop2_q, stop2_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DBIT-1:0] fifo_rdata;
  logic [CW-1:0]   fifo_count;

  logic [PAR_MAX_W-1:0] data_ext;
  logic [TW-1:0]        tick_last;
  logic                 tick_end;
  logic                 load;

  assign tx_ready  = (fifo_count != CW'(DEPTH));
  assign fifo_push = tx_valid && !fifo_full;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

  uart_sync_fifo #(
    .WIDTH (DBIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (tx_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    data_ext              = '0;
    data_ext[DBIT-1:0]    = data_q;
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    par_d    = par_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    load     = 1'b0;

    tick_last = (state_q == ST_STOP && stop2_q) ? TICK_LAST2 : TICK_LAST1;
    tick_end  = stick && (tick_q == tick_last);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (tick_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else if (stick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (tick_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            if (par_enabled(par_q)) begin
              state_d = ST_PARITY;
              tx_d    = parity_bit(data_ext, par_q);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            tx_d  = shift_d[0];
          end
        end else if (stick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_PARITY: begin
        if (tick_end) begin
          tick_d  = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else if (stick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (tick_end) begin
          done_d = 1'b1;
          tick_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (fifo_empty) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end else begin
            load = 1'b1;
          end
        end else if (stick) begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      data_d   = fifo_rdata;
      par_d    = par_mode;
      stop2_d  = stop2;
      tick_d   = '0;
      bit_d    = '0;
      state_d  = ST_START;
      tx_d     = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
